// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the RV32I load/store unit,
// plus the combinational legality/alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Only the two low address bits matter for alignment, so only they are passed in.
    function automatic logic lsu_fault(input logic       write,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        if (write)
            legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        else
            legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                    (funct3 == LBU) || (funct3 == LHU);
        misaligned = (funct3[1] && (addr_lo != 2'b00)) ||
                     ((funct3[1:0] == 2'b01) && addr_lo[0]);
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time, issues it to a
// one-cycle-latency memory and returns a single response pulse.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] waddr_hold;
    logic [31:0] wdata_hold;
    logic [31:0] raddr_hold;

    logic issue_store;
    logic issue_load;

    assign issue_store = (state == ISSUE) && write_q;
    assign issue_load  = (state == ISSUE) && !write_q;

    // The captured request drives memory during ISSUE; the hold registers
    // keep the last driven address/data visible for the rest of the time.
    assign mem_write         = issue_store;
    assign mem_funct3        = (state == ISSUE) ? funct3_q : LW;
    assign mem_write_address = issue_store ? addr_q  : waddr_hold;
    assign mem_write_data    = issue_store ? wdata_q : wdata_hold;
    assign mem_read_address  = issue_load  ? addr_q  : raddr_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            write_q    <= 1'b0;
            funct3_q   <= LW;
            addr_q     <= '0;
            wdata_q    <= '0;
            waddr_hold <= '0;
            wdata_hold <= '0;
            raddr_hold <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (lsu_fault(req_write, req_funct3, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (write_q) begin
                        waddr_hold <= addr_q;
                        wdata_hold <= wdata_q;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end else begin
                        raddr_hold <= addr_q;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Memory already extended the value; pass it through untouched.
                    resp_rdata <= mem_read_data;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at RV32I values.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port req_valid  input  1  core presents a load/store request.
REQ-006 Port req_ready  output  1  unit accepts a request this cycle.
REQ-007 Port req_write  input  1  1 = store, 0 = load.
REQ-008 Port req_funct3  input  3  RV32I funct3 of the load/store.
REQ-009 Port req_addr  input  32  byte address.
REQ-010 Port req_wdata  input  32  store data; bytes/halves are taken from the low bits.
REQ-011 Port resp_valid  output  1  one-cycle pulse; the request has completed.
REQ-012 Port resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-013 Port resp_fault  output  1  misaligned or illegal access, valid with resp_valid.
REQ-014 Ports mem_write (out, 1), mem_funct3 (out, 3), mem_write_address (out, 32), mem_write_data (out, 32), mem_read_address (out, 32) and mem_read_data (in, 32) SHALL connect one-to-one to the memory's write_mem, funct3, write_address, write_data, read_address and read_data.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; write flag, funct3, address and wdata SHALL be captured into registers on acceptance.
REQ-017 Legal load funct3 values SHALL be 000, 001, 010, 100 and 101; legal store funct3 values SHALL be 000, 001 and 010.
REQ-018 An access SHALL be misaligned when:
  - funct3[1]=1 and addr[1:0]!=00, or
  - funct3[1:0]=01 and addr[0]=1.
REQ-019 An illegal or misaligned request accepted at cycle N SHALL go IDLE->RESP and assert resp_valid=1 and resp_fault=1 at N+1.
  - mem_write SHALL stay 0.
  - resp_rdata SHALL be 0.
REQ-020 A legal store accepted at N SHALL drive the following in ISSUE at N+1:
  - mem_write=1 for exactly that one cycle;
  - mem_write_address = captured address;
  - mem_write_data = captured wdata;
  - mem_funct3 = captured funct3.
  It SHALL then go to RESP with resp_valid=1, resp_fault=0 at N+2.
REQ-021 A legal load accepted at N SHALL drive mem_read_address = captured address and mem_funct3 = captured funct3 in ISSUE at N+1.
REQ-022 The loaded value SHALL be sampled from mem_read_data in WAIT at N+2 (one-cycle memory read latency) into resp_rdata.
REQ-023 The load SHALL complete in RESP with resp_valid=1 at N+3.
REQ-024 Sign/zero extension SHALL be taken from the memory output as-is; the unit SHALL NOT re-extend.
REQ-025 Outside ISSUE, the memory outputs SHALL take these values:
  - mem_write=0;
  - mem_funct3=3'b010;
  - mem_write_address, mem_write_data and mem_read_address held at their last driven values.
REQ-026 RESP SHALL last exactly one cycle and return to IDLE, so back-to-back legal loads complete every 4 cycles.
REQ-027 Each accepted request SHALL produce exactly one resp_valid pulse; no response SHALL be produced without an accepted request.
REQ-028 Peripheral addresses (0xFFFFFFF4..0xFFFFFFFF) and out-of-range addresses SHALL NOT fault; they are passed to memory unchanged.

Reset
REQ-029 While rst=1 the block SHALL enter IDLE and drive the following on the next edge:
  - req_ready=1;
  - resp_valid=0, resp_fault=0, resp_rdata=0;
  - mem_write=0, mem_funct3=3'b010;
  - all mem addresses and mem_write_data = 0.
REQ-030 Reset asserted in ISSUE, WAIT or RESP SHALL abort the transaction:
  - no resp_valid pulse;
  - mem_write=0 from the reset edge onward.

Structure
REQ-031 Package lsu_pkg SHALL hold the FSM state enum and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-032 The block SHALL be a single module with no sub-modules; the legality/misalignment check SHALL be a combinational function in lsu_pkg.

Verification
REQ-033 Store then load:
  - SW addr 0x100, wdata 0xDEADBEEF -> mem_write pulse at N+1, resp_valid at N+2.
  - LW addr 0x100 -> resp_rdata=0xDEADBEEF at N+3.
REQ-034 Byte load with sign extension: LB addr 0x103 after the store in REQ-033 -> resp_rdata=0xFFFFFFDE; LBU addr 0x103 -> 0x000000DE.
REQ-035 Misaligned accesses: LW addr 0x102 and SH addr 0x101 -> resp_fault=1 at N+1, and mem_write never asserted.
REQ-036 Illegal funct3: store with funct3 100 -> resp_fault=1; load with funct3 011 -> resp_fault=1.
REQ-037 Reset mid-operation: assert rst in WAIT of LW 0x100 -> no resp_valid, and req_ready=1 after the reset edge.
REQ-038 Peripheral write: SW addr 0xFFFFFFFC, wdata 0x80402010 -> resp_fault=0, and a following LW of 0xFFFFFFFC returns 0x80402010.
